// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering: byte enables, store shifting, load extraction and
// alignment check for one access of the given size at a byte offset
// within the doubleword.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  size_t             i_size,
  input  logic [2:0]        i_off,
  input  logic [DATA_W-1:0] i_sdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [7:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_ldata,
  output logic              o_misalign
);

  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_rshift;

  // Lane enables, shifted data and zero-extended load value per size
  always_comb begin
    w_shamt    = {i_off, 3'b000};
    o_wdata    = i_sdata << w_shamt;
    w_rshift   = i_rdata >> w_shamt;
    o_be       = 8'h00;
    o_ldata    = '0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 8'h01 << i_off;
        o_ldata = {56'd0, w_rshift[7:0]};
      end
      SZ_H: begin
        o_be       = 8'h03 << i_off;
        o_ldata    = {48'd0, w_rshift[15:0]};
        o_misalign = i_off[0];
      end
      SZ_W: begin
        o_be       = 8'h0F << i_off;
        o_ldata    = {32'd0, w_rshift[31:0]};
        o_misalign = |i_off[1:0];
      end
      default: begin
        o_be       = 8'hFF;
        o_ldata    = w_rshift;
        o_misalign = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, req/ack data-memory FSM with watchdog,
// and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        xfer_size,
  input  logic              reg_write,
  input  logic [RD_W-1:0]   rd,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] alu_result_wb,
  output logic              wb_fault
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WAIT);

  // EX/MEM register
  logic              r_valid, r_kill, r_mrd, r_mwr, r_reg_write;
  logic [DATA_W-1:0] r_alu, r_sdata;
  size_t             r_size;
  logic [RD_W-1:0]   r_rd;

  // FSM and watchdog
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;

  // MEM/WB register
  logic              r_wb_valid, r_wb_reg_write, r_wb_fault;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_memop, w_timeout, w_req, w_stall, w_fault, w_retire;
  logic [7:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_ldata;
  logic              w_mis;

  mem_lane_align u_align (
    .i_size     (r_size),
    .i_off      (r_alu[2:0]),
    .i_sdata    (r_sdata),
    .i_rdata    (dmem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_mis)
  );

  // Capture from execute when not stalled; a flush during a stall marks the held op killed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_kill      <= 1'b0;
      r_mrd       <= 1'b0;
      r_mwr       <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu       <= '0;
      r_sdata     <= '0;
      r_size      <= SZ_B;
      r_rd        <= '0;
    end else if (!w_stall) begin
      r_valid     <= ex_valid & ~flush;
      r_kill      <= 1'b0;
      r_mrd       <= mem_read;
      r_mwr       <= mem_write;
      r_reg_write <= reg_write;
      r_alu       <= alu_result;
      r_sdata     <= store_data;
      r_size      <= size_t'(xfer_size);
      r_rd        <= rd;
    end else if (flush) begin
      r_kill <= 1'b1;
    end
  end

  // State register and watchdog counter (cleared in IDLE, counts BUSY cycles)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
    end
  end

  // Next state, request, stall and retirement decode
  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_memop   = r_valid & (r_mrd | r_mwr);
    w_timeout = (MAX_WAIT != 0) && (r_state == BUSY) && (r_cnt == LP_MAX);
    case (r_state)
      IDLE: begin
        if (w_memop && !w_mis) begin
          w_req = 1'b1;
          if (!dmem_ack) w_next = BUSY;
        end
      end
      default: begin
        if (w_timeout) begin
          w_next = IDLE;
        end else begin
          w_req = 1'b1;
          if (dmem_ack) w_next = IDLE;
        end
      end
    endcase
    w_stall  = w_memop & ~w_mis & ~dmem_ack & ~w_timeout;
    w_fault  = w_memop & (w_mis | w_timeout);
    w_retire = r_valid & ~r_kill & ~w_stall;
  end

  // MEM/WB register; data holds when nothing retires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_fault     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
    end else begin
      r_wb_valid     <= w_retire;
      r_wb_fault     <= w_retire & w_fault;
      r_wb_reg_write <= w_retire & r_reg_write & ~w_fault & ~r_mwr;
      if (w_retire) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= (r_mrd && !r_mwr && !w_fault) ? w_ldata : r_alu;
      end
    end
  end

  assign stall          = w_stall;
  assign alu_result_mem = r_alu;
  assign dmem_req       = w_req;
  assign dmem_we        = w_req & r_mwr;
  assign dmem_addr      = {r_alu[DATA_W-1:3], 3'b000};
  assign dmem_wdata     = w_req ? w_wdata : '0;
  assign dmem_be        = w_req ? w_be : 8'h00;
  assign wb_valid       = r_wb_valid;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_rd          = r_wb_rd;
  assign alu_result_wb  = r_wb_data;
  assign wb_fault       = r_wb_fault;

endmodule
